tile_ram_arbiter: RTL and testbench

TILE_RAM_ARBITER -- requirements
Module: tile_ram_arbiter

---
 rtl/tile_ram_arbiter.sv | 91 +++++++++
 tb/tb_tile_ram_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/tile_ram_arbiter.sv
// Single-port tile RAM arbiter: renderer reads always win, CPU writes wait in a
// FIFO and commit in free slots (only during vblank when TEAR_FREE=1).
module tile_ram_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int TEAR_FREE  = 1
) (
  input  logic                          vga_clk,
  input  logic                          rst,
  input  logic                          vblank,
  input  logic                          rd_req,
  input  logic [ADDR_W-1:0]             rd_addr,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          rd_valid,
  input  logic                          wr_valid,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  output logic                          wr_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic [1:0]                    state_dbg
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  // Handshake: a write transfers on a cycle where wr_valid && wr_ready at the
  // rising edge; wr_ready depends only on the registered level, never on a pop.
  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [ADDR_W-1:0]   fifo_addr_q [FIFO_DEPTH];
  logic [DATA_W-1:0]   fifo_data_q [FIFO_DEPTH];
  logic                push, drain, tear_ok;

  assign wr_ready   = (level_q < LVL_W'(FIFO_DEPTH));
  assign fifo_level = level_q;
  assign rd_valid   = (state_q == READ);
  assign rd_data    = mem_rdata;
  assign state_dbg  = state_q;

  always_comb begin
    tear_ok   = (TEAR_FREE == 0) || vblank;
    push      = wr_valid && wr_ready;
    // Writes never commit in a reset cycle, so discarded entries stay discarded.
    drain     = !rd_req && (level_q != '0) && tear_ok && !rst;
    mem_en    = rd_req || drain;
    mem_we    = drain;
    mem_addr  = rd_req ? rd_addr : fifo_addr_q[rd_ptr_q];
    mem_wdata = fifo_data_q[rd_ptr_q];

    state_d = IDLE;
    if (rd_req)     state_d = READ;
    else if (drain) state_d = WRITE;

    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(drain);
    level_d  = level_q + LVL_W'(push) - LVL_W'(drain);

    if (rst) begin
      state_d  = IDLE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end
  end

  always_ff @(posedge vga_clk) begin
    state_q  <= state_d;
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
    level_q  <= level_d;
  end

  // Queue storage needs no reset: the level gates every use of an entry.
  always_ff @(posedge vga_clk) begin
    if (push && !rst) begin
      fifo_addr_q[wr_ptr_q] <= wr_addr;
      fifo_data_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: tb/tb_tile_ram_arbiter.sv
// Bench for tile_ram_arbiter: stimulus table, directed corner sequences and
// random traffic, all checked against a queue-based model of committed RAM.
module tb_tile_ram_arbiter;

  localparam int DEPTH = 4;
  localparam int TF    = 1;

  logic       vga_clk = 1'b0;
  logic       rst, vblank, rd_req, wr_valid;
  logic [7:0] rd_addr, wr_addr, wr_data;
  logic [7:0] rd_data, mem_addr, mem_wdata, mem_rdata;
  logic       rd_valid, wr_ready, mem_en, mem_we;
  logic [2:0] fifo_level;
  logic [1:0] state_dbg;

  always #5 vga_clk = ~vga_clk;

  tile_ram_arbiter #(.ADDR_W(8), .DATA_W(8), .FIFO_DEPTH(DEPTH), .TEAR_FREE(TF)) dut (
    .vga_clk(vga_clk), .rst(rst), .vblank(vblank),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .fifo_level(fifo_level), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .state_dbg(state_dbg)
  );

  // External single-port RAM, one cycle read latency.
  logic [7:0] ram [256];
  always @(posedge vga_clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] = mem_wdata;
      else        mem_rdata = ram[mem_addr];
    end
  end

  // Reference model: pending writes as {addr,data}, committed RAM image.
  logic [15:0] exp_q [$];
  logic [7:0]  model_ram [256];
  logic        rd_pend;
  logic [7:0]  rd_exp;
  int          n_vec, n_err, n_commit, n_rv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    rst = 0; vblank = 0; rd_req = 0; rd_addr = 0;
    wr_valid = 0; wr_addr = 0; wr_data = 0;
  endtask

  // Called just after a falling edge with inputs set; checks, advances model.
  task automatic step();
    int   sz;
    logic drain;
    logic [15:0] head;
    #1;
    sz    = exp_q.size();
    drain = !rd_req && (sz > 0) && (TF == 0 || vblank) && !rst;
    head  = (sz > 0) ? exp_q[0] : 16'h0;
    chk("mem_en", mem_en, rd_req || drain);
    chk("mem_we", mem_we, drain);
    if (rd_req) chk("rd_addr", mem_addr, rd_addr);
    if (drain) begin
      chk("wr_addr", mem_addr, head[15:8]);
      chk("wr_data", mem_wdata, head[7:0]);
    end
    chk("wr_ready", wr_ready, sz < DEPTH);
    chk("level", fifo_level, sz);
    chk("rd_valid", rd_valid, rd_pend);
    if (rd_pend && rd_valid) chk("rd_data", rd_data, rd_exp);
    n_commit += int'(mem_we === 1'b1);
    n_rv     += int'(rd_valid === 1'b1);
    if (drain) begin
      model_ram[head[15:8]] = head[7:0];
      void'(exp_q.pop_front());
    end
    rd_pend = rd_req;
    rd_exp  = model_ram[rd_addr];
    if (wr_valid && sz < DEPTH) exp_q.push_back({wr_addr, wr_data});
    if (rst) begin
      exp_q.delete();
      rd_pend = 0;
    end
    @(posedge vga_clk);
    @(negedge vga_clk);
  endtask

  typedef struct {
    logic rd; logic [7:0] ra; logic vb; logic wv; logic [7:0] wa; logic [7:0] wd;
    logic e_en; logic e_we; logic [7:0] e_addr; logic [2:0] e_lvl; logic e_rdy; logic e_rv;
  } vec_t;
  vec_t tbl [12];

  initial begin
    int c0, r0;
    n_vec = 0; n_err = 0; n_commit = 0; n_rv = 0; rd_pend = 0; rd_exp = 0;
    mem_rdata = 0;
    for (int i = 0; i < 256; i++) begin
      ram[i]       = 8'((i * 7 + 3) % 256);
      model_ram[i] = 8'((i * 7 + 3) % 256);
    end
    //            rd ra     vb wv wa     wd     en we addr   lvl rdy rv
    tbl[0]  = '{0, 8'h00, 0, 1, 8'h20, 8'hA0, 0, 0, 8'h00, 0, 1, 0};
    tbl[1]  = '{0, 8'h00, 0, 1, 8'h21, 8'hA1, 0, 0, 8'h00, 1, 1, 0};
    tbl[2]  = '{0, 8'h00, 0, 1, 8'h22, 8'hA2, 0, 0, 8'h00, 2, 1, 0};
    tbl[3]  = '{0, 8'h00, 0, 1, 8'h23, 8'hA3, 0, 0, 8'h00, 3, 1, 0};
    tbl[4]  = '{0, 8'h00, 0, 1, 8'h24, 8'hA4, 0, 0, 8'h00, 4, 0, 0};
    tbl[5]  = '{0, 8'h00, 1, 0, 8'h00, 8'h00, 1, 1, 8'h20, 4, 0, 0};
    tbl[6]  = '{0, 8'h00, 1, 0, 8'h00, 8'h00, 1, 1, 8'h21, 3, 1, 0};
    tbl[7]  = '{0, 8'h00, 1, 0, 8'h00, 8'h00, 1, 1, 8'h22, 2, 1, 0};
    tbl[8]  = '{0, 8'h00, 1, 0, 8'h00, 8'h00, 1, 1, 8'h23, 1, 1, 0};
    tbl[9]  = '{0, 8'h00, 1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 1, 0};
    tbl[10] = '{1, 8'h20, 0, 0, 8'h00, 8'h00, 1, 0, 8'h20, 0, 1, 0};
    tbl[11] = '{0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 1, 1};

    // Reset
    idle(); rst = 1;
    @(posedge vga_clk); @(negedge vga_clk);
    step();
    rst = 0;
    #1;
    chk("reset_state", state_dbg, 2'd0);
    chk("reset_level", fifo_level, 3'd0);
    chk("reset_ready", wr_ready, 1'b1);
    chk("reset_rv", rd_valid, 1'b0);
    step();

    // Table: fill while vblank low, then in-order drain during vblank
    foreach (tbl[i]) begin
      idle();
      rd_req = tbl[i].rd; rd_addr = tbl[i].ra; vblank = tbl[i].vb;
      wr_valid = tbl[i].wv; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
      #1;
      chk($sformatf("tbl%0d_en", i), mem_en, tbl[i].e_en);
      chk($sformatf("tbl%0d_we", i), mem_we, tbl[i].e_we);
      if (tbl[i].e_en) chk($sformatf("tbl%0d_addr", i), mem_addr, tbl[i].e_addr);
      chk($sformatf("tbl%0d_lvl", i), fifo_level, tbl[i].e_lvl);
      chk($sformatf("tbl%0d_rdy", i), wr_ready, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_rv", i), rd_valid, tbl[i].e_rv);
      step();
    end
    idle();
    #1;
    chk("tbl_readback", rd_data, 8'hA0);

    // Reads starve commits even in vblank; two queued writes land afterwards
    for (int i = 0; i < 2; i++) begin
      idle(); wr_valid = 1; wr_addr = 8'h40 + 8'(i); wr_data = 8'h60 + 8'(i); step();
    end
    c0 = n_commit; r0 = n_rv;
    for (int i = 0; i < 10; i++) begin
      idle(); vblank = 1; rd_req = 1; rd_addr = 8'(i); step();
    end
    chk("starve_commits", n_commit - c0, 0);
    for (int i = 0; i < 2; i++) begin
      idle(); vblank = 1; step();
    end
    chk("starve_rv", n_rv - r0, 10);
    chk("after_commits", n_commit - c0, 2);

    // Read-before-commit returns old data, read-after-commit new data
    idle(); wr_valid = 1; wr_addr = 8'h10; wr_data = 8'h5A; step();
    idle(); rd_req = 1; rd_addr = 8'h10; step();
    idle(); #1; chk("old_value", rd_data, 8'(16 * 7 + 3));
    idle(); vblank = 1; step();
    idle(); rd_req = 1; rd_addr = 8'h10; step();
    idle(); #1; chk("new_value", rd_data, 8'h5A);
    step();

    // Full queue with wr_valid held: one drain admits exactly one push
    for (int i = 0; i < 4; i++) begin
      idle(); wr_valid = 1; wr_addr = 8'h50 + 8'(i); wr_data = 8'h70 + 8'(i); step();
    end
    idle(); wr_valid = 1; wr_addr = 8'h58; wr_data = 8'hEE; vblank = 1; step();
    vblank = 0; #1; chk("refill_ready", wr_ready, 1'b1); step();
    #1; chk("refill_level", fifo_level, 3'd4); chk("refill_full", wr_ready, 1'b0);
    step();
    for (int i = 0; i < 5; i++) begin
      idle(); vblank = 1; step();
    end

    // Reset discards queued writes and the in-flight read
    for (int i = 0; i < 3; i++) begin
      idle(); wr_valid = 1; wr_addr = 8'h30 + 8'(i); wr_data = 8'h90 + 8'(i); step();
    end
    idle(); rd_req = 1; rd_addr = 8'h05; step();
    idle(); rst = 1; rd_req = 1; rd_addr = 8'h06; step();
    c0 = n_commit;
    idle(); vblank = 1; #1;
    chk("rst_rv", rd_valid, 1'b0);
    chk("rst_level", fifo_level, 3'd0);
    for (int i = 0; i < 4; i++) step();
    chk("rst_no_commit", n_commit - c0, 0);

    // Random traffic, narrow address range to collide reads with pending writes
    for (int i = 0; i < 500; i++) begin
      idle();
      rst      = ($urandom_range(0, 79) == 0);
      vblank   = ($urandom_range(0, 2) == 0);
      rd_req   = ($urandom_range(0, 1) == 0);
      rd_addr  = 8'($urandom_range(0, 15));
      wr_valid = ($urandom_range(0, 1) == 0);
      wr_addr  = 8'($urandom_range(0, 15));
      wr_data  = 8'($urandom);
      step();
    end
    idle();
    for (int i = 0; i < 6; i++) begin
      vblank = 1; step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
